// File: rtl/branch_resolve_unit.sv
// Branch resolution: in-order FIFO of fetch-time predictions, checked against EX outcomes.
// Produces fetch redirects, predictor training pulses and saturating performance counters.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int TARGET_WIDTH = 32,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetchValid,
    input  logic [31:0]             fetchPc,
    input  logic                    fetchHit,
    input  logic [TARGET_WIDTH-1:0] fetchTarget,
    output logic                    fetchReady,
    input  logic                    exValid,
    input  logic                    exBranch,
    input  logic                    exTaken,
    input  logic [TARGET_WIDTH-1:0] exTarget,
    output logic                    redirectValid,
    output logic [31:0]             redirectPc,
    output logic                    updBranch,
    output logic                    updTaken,
    output logic [31:0]             updPc,
    output logic [TARGET_WIDTH-1:0] updTarget,
    output logic [CNT_WIDTH-1:0]    branchCnt,
    output logic [CNT_WIDTH-1:0]    mispredCnt,
    output logic                    underflowErr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0]     OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0]     OCC_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    logic [31:0]             pc_mem_q  [DEPTH];
    logic                    tkn_mem_q [DEPTH];
    logic [TARGET_WIDTH-1:0] tgt_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;

    logic                    redirect_valid_q, redirect_valid_d;
    logic [31:0]             redirect_pc_q, redirect_pc_d;
    logic                    upd_branch_q, upd_branch_d;
    logic                    upd_taken_q, upd_taken_d;
    logic [31:0]             upd_pc_q, upd_pc_d;
    logic [TARGET_WIDTH-1:0] upd_target_q, upd_target_d;
    logic [CNT_WIDTH-1:0]    branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]    mispred_cnt_q, mispred_cnt_d;
    logic                    underflow_q, underflow_d;

    logic                    full_s, empty_s, push_s, pop_s, mispred_s;
    logic [31:0]             head_pc_s;
    logic                    head_tkn_s;
    logic [TARGET_WIDTH-1:0] head_tgt_s;

    assign full_s     = (count_q == OCC_FULL);
    assign empty_s    = (count_q == {OCC_W{1'b0}});
    assign fetchReady = !full_s | exValid;
    assign push_s     = fetchValid & fetchReady & !redirect_valid_q;
    assign pop_s      = exValid & !empty_s;
    assign head_pc_s  = pc_mem_q[rd_ptr_q];
    assign head_tkn_s = tkn_mem_q[rd_ptr_q];
    assign head_tgt_s = tgt_mem_q[rd_ptr_q];

    // Mispredict detection for the entry being popped.
    always_comb begin
        mispred_s = 1'b0;
        if (pop_s) begin
            if (exBranch) begin
                mispred_s = (head_tkn_s != exTaken) |
                            (exTaken & head_tkn_s & (head_tgt_s != exTarget));
            end else begin
                mispred_s = head_tkn_s;
            end
        end else begin
            mispred_s = 1'b0;
        end
    end

    // Pointer and occupancy next state; a mispredict flushes wrong-path entries and the same-cycle push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mispred_s) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + OCC_ONE;
                2'b01:   count_d = count_q - OCC_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Redirect, training and counter next state.
    always_comb begin
        redirect_valid_d = mispred_s;
        redirect_pc_d    = 32'd0;
        upd_branch_d     = 1'b0;
        upd_taken_d      = 1'b0;
        upd_pc_d         = 32'd0;
        upd_target_d     = {TARGET_WIDTH{1'b0}};
        branch_cnt_d     = branch_cnt_q;
        mispred_cnt_d    = mispred_cnt_q;
        underflow_d      = underflow_q | (exValid & empty_s);
        if (mispred_s) begin
            if (exBranch & exTaken) begin
                redirect_pc_d = 32'(exTarget);
            end else begin
                redirect_pc_d = head_pc_s + 32'd4;
            end
            mispred_cnt_d = sat_inc(mispred_cnt_q);
        end else begin
            redirect_pc_d = 32'd0;
        end
        if (pop_s) begin
            upd_branch_d = exBranch;
            upd_taken_d  = exBranch & exTaken;
            upd_pc_d     = head_pc_s;
            upd_target_d = exTarget;
            if (exBranch) begin
                branch_cnt_d = sat_inc(branch_cnt_q);
            end else begin
                branch_cnt_d = branch_cnt_q;
            end
        end else begin
            upd_branch_d = 1'b0;
        end
    end

    // Prediction storage; only the write slot changes on an accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= 32'd0;
                tkn_mem_q[i] <= 1'b0;
                tgt_mem_q[i] <= {TARGET_WIDTH{1'b0}};
            end
        end else if (push_s && !mispred_s) begin
            pc_mem_q[wr_ptr_q]  <= fetchPc;
            tkn_mem_q[wr_ptr_q] <= fetchHit;
            tgt_mem_q[wr_ptr_q] <= fetchTarget;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q         <= {PTR_W{1'b0}};
            rd_ptr_q         <= {PTR_W{1'b0}};
            count_q          <= {OCC_W{1'b0}};
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            upd_branch_q     <= 1'b0;
            upd_taken_q      <= 1'b0;
            upd_pc_q         <= 32'd0;
            upd_target_q     <= {TARGET_WIDTH{1'b0}};
            branch_cnt_q     <= {CNT_WIDTH{1'b0}};
            mispred_cnt_q    <= {CNT_WIDTH{1'b0}};
            underflow_q      <= 1'b0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            upd_branch_q     <= upd_branch_d;
            upd_taken_q      <= upd_taken_d;
            upd_pc_q         <= upd_pc_d;
            upd_target_q     <= upd_target_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
            underflow_q      <= underflow_d;
        end
    end

    assign redirectValid = redirect_valid_q;
    assign redirectPc    = redirect_pc_q;
    assign updBranch     = upd_branch_q;
    assign updTaken      = upd_taken_q;
    assign updPc         = upd_pc_q;
    assign updTarget     = upd_target_q;
    assign branchCnt     = branch_cnt_q;
    assign mispredCnt    = mispred_cnt_q;
    assign underflowErr  = underflow_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: hand-computed expectations, 4-bit counters to reach saturation.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetchValid, fetchHit, fetchReady;
    logic [31:0] fetchPc, fetchTarget;
    logic        exValid, exBranch, exTaken;
    logic [31:0] exTarget;
    logic        redirectValid, updBranch, updTaken, underflowErr;
    logic [31:0] redirectPc, updPc, updTarget;
    logic [3:0]  branchCnt, mispredCnt;

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .TARGET_WIDTH(32), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .fetchValid(fetchValid), .fetchPc(fetchPc), .fetchHit(fetchHit),
        .fetchTarget(fetchTarget), .fetchReady(fetchReady),
        .exValid(exValid), .exBranch(exBranch), .exTaken(exTaken), .exTarget(exTarget),
        .redirectValid(redirectValid), .redirectPc(redirectPc),
        .updBranch(updBranch), .updTaken(updTaken), .updPc(updPc), .updTarget(updTarget),
        .branchCnt(branchCnt), .mispredCnt(mispredCnt), .underflowErr(underflowErr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic hit, input logic [31:0] tgt);
        fetchValid = 1'b1; fetchPc = pc; fetchHit = hit; fetchTarget = tgt;
        step();
        fetchValid = 1'b0;
    endtask

    task automatic pop(input logic br, input logic tk, input logic [31:0] tgt);
        exValid = 1'b1; exBranch = br; exTaken = tk; exTarget = tgt;
        step();
        exValid = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic rv, input logic [31:0] rpc,
                             input logic ub, input logic ut, input logic [31:0] upc);
        check_eq({tag, ".redirectValid"}, 32'(redirectValid), 32'(rv));
        if (rv) check_eq({tag, ".redirectPc"}, redirectPc, rpc);
        else    check_eq({tag, ".redirectPc"}, redirectPc, 32'd0);
        check_eq({tag, ".updBranch"}, 32'(updBranch), 32'(ub));
        check_eq({tag, ".updTaken"}, 32'(updTaken), 32'(ut));
        check_eq({tag, ".updPc"}, updPc, upc);
    endtask

    task automatic check_cnt(input string tag, input int br, input int mp);
        check_eq({tag, ".branchCnt"}, 32'(branchCnt), 32'(br));
        check_eq({tag, ".mispredCnt"}, 32'(mispredCnt), 32'(mp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        fetchValid = 1'b0; fetchPc = 32'd0; fetchHit = 1'b0; fetchTarget = 32'd0;
        exValid = 1'b0; exBranch = 1'b0; exTaken = 1'b0; exTarget = 32'd0;
        step(); step();
        check_out("reset", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_cnt("reset", 0, 0);
        check_eq("reset.underflowErr", 32'(underflowErr), 32'd0);
        check_eq("reset.fetchReady", 32'(fetchReady), 32'd1);
        rst = 1'b1;
        step();

        // correct taken prediction
        push(32'h100, 1'b1, 32'h200);
        pop(1'b1, 1'b1, 32'h200);
        check_out("hit", 1'b0, 32'd0, 1'b1, 1'b1, 32'h100);
        check_eq("hit.updTarget", updTarget, 32'h200);
        check_cnt("hit", 1, 0);
        step();
        check_out("hit_idle", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // direction mispredict; pushes in the pop cycle and redirect cycle are dropped
        push(32'h100, 1'b0, 32'h0);
        push(32'h104, 1'b0, 32'h0);
        fetchValid = 1'b1; fetchPc = 32'h998; fetchHit = 1'b0; fetchTarget = 32'h0;
        exValid = 1'b1; exBranch = 1'b1; exTaken = 1'b1; exTarget = 32'h400;
        step();
        exValid = 1'b0; fetchPc = 32'h999;
        check_out("dir_mp", 1'b1, 32'h400, 1'b1, 1'b1, 32'h100);
        check_cnt("dir_mp", 2, 1);
        step();
        fetchValid = 1'b0;
        check_out("dir_mp_after", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);

        // refill from empty: full after exactly four pushes
        push(32'h10, 1'b0, 32'h0);
        push(32'h14, 1'b0, 32'h0);
        push(32'h18, 1'b0, 32'h0);
        check_eq("fill3.fetchReady", 32'(fetchReady), 32'd1);
        push(32'h1c, 1'b0, 32'h0);
        check_eq("fill4.fetchReady", 32'(fetchReady), 32'd0);
        fetchValid = 1'b1; fetchPc = 32'h20; fetchHit = 1'b0;
        exValid = 1'b1; exBranch = 1'b0; exTaken = 1'b0; exTarget = 32'h0;
        #1;
        check_eq("full_pop.fetchReady", 32'(fetchReady), 32'd1);
        step();
        fetchValid = 1'b0;
        check_out("full_pop", 1'b0, 32'd0, 1'b0, 1'b0, 32'h10);
        exValid = 1'b0;
        #1;
        check_eq("still_full.fetchReady", 32'(fetchReady), 32'd0);
        exValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_out($sformatf("drain%0d", i), 1'b0, 32'd0, 1'b0, 1'b0, 32'h14 + 32'(4 * i));
        end
        exValid = 1'b0;
        #1;
        check_eq("drained.fetchReady", 32'(fetchReady), 32'd1);
        step();
        check_out("drained_idle", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_cnt("drained", 2, 1);

        // predicted taken on a non-branch
        push(32'h300, 1'b1, 32'h500);
        pop(1'b0, 1'b0, 32'h0);
        check_out("nonbr_mp", 1'b1, 32'h304, 1'b0, 1'b0, 32'h300);
        check_cnt("nonbr_mp", 2, 2);
        step();

        // right direction, wrong target
        push(32'h600, 1'b1, 32'h700);
        pop(1'b1, 1'b1, 32'h704);
        check_out("tgt_mp", 1'b1, 32'h704, 1'b1, 1'b1, 32'h600);
        check_eq("tgt_mp.updTarget", updTarget, 32'h704);
        check_cnt("tgt_mp", 3, 3);
        step();

        // correct not-taken branch
        push(32'h800, 1'b0, 32'h0);
        pop(1'b1, 1'b0, 32'h804);
        check_out("nt_ok", 1'b0, 32'd0, 1'b1, 1'b0, 32'h800);
        check_eq("nt_ok.updTarget", updTarget, 32'h804);
        check_cnt("nt_ok", 4, 3);

        // branch counter saturates at 4'hf
        for (int i = 0; i < 12; i++) begin
            push(32'h900, 1'b1, 32'h940);
            pop(1'b1, 1'b1, 32'h940);
        end
        check_cnt("sat_edge", 15, 3);
        for (int i = 0; i < 2; i++) begin
            push(32'h900, 1'b1, 32'h940);
            pop(1'b1, 1'b1, 32'h940);
        end
        check_cnt("sat_hold", 15, 3);
        check_eq("sat_hold.redirectValid", 32'(redirectValid), 32'd0);
        step();

        // underflow: ignored pop, sticky error
        pop(1'b1, 1'b1, 32'h0);
        check_eq("uflow.underflowErr", 32'(underflowErr), 32'd1);
        check_out("uflow", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();
        check_eq("uflow_sticky.underflowErr", 32'(underflowErr), 32'd1);

        // async reset mid-stream with entries in flight and an update pulse active
        push(32'hA00, 1'b1, 32'hB00);
        push(32'hA04, 1'b0, 32'h0);
        push(32'hA08, 1'b0, 32'h0);
        pop(1'b1, 1'b1, 32'hB00);
        check_out("pre_rst", 1'b0, 32'd0, 1'b1, 1'b1, 32'hA00);
        rst = 1'b0;
        #1;
        check_out("mid_rst", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_cnt("mid_rst", 0, 0);
        check_eq("mid_rst.underflowErr", 32'(underflowErr), 32'd0);
        check_eq("mid_rst.fetchReady", 32'(fetchReady), 32'd1);
        step();
        rst = 1'b1;
        step();
        check_out("post_rst", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        pop(1'b1, 1'b1, 32'hB00);
        check_eq("post_rst_pop.underflowErr", 32'(underflowErr), 32'd1);
        check_out("post_rst_pop", 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        check_cnt("post_rst_pop", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
